// File: rtl/nf_bypass_merge_avlstrm_pkg.sv
// nf_bypass_merge_avlstrm_pkg: shared token layout, FSM states and stats register indices
package nf_bypass_merge_avlstrm_pkg;
  localparam int TOK_META_W = 128;
  localparam int TOK_CH_W = 3;
  typedef struct packed {
    logic [TOK_META_W-1:0] meta;
    logic                  chk;
    logic [TOK_CH_W-1:0]   ch_id;
  } ord_tok_t;
  typedef enum logic [1:0] {S_IDLE, S_META, S_PKT} state_e;
  localparam int REG_MERGE_PKT   = 0;
  localparam int REG_MERGE_BYP   = 1;
  localparam int REG_MERGE_CHK   = 2;
  localparam int REG_MERGE_BADCH = 3;
  localparam int REG_MERGE_STALL = 4;
  localparam int NUM_REGS        = 5;
endpackage

// File: rtl/nf_lane_mux.sv
// nf_lane_mux: selects the bypass lane or one checked lane onto the output beat and routes ready back
module nf_lane_mux #(
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6,
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 3
) (
  input  logic                      en_i,
  input  logic                      byp_sel_i,
  input  logic [CH_W-1:0]           ch_i,
  input  logic                      byp_valid_i,
  input  logic [DATA_W-1:0]         byp_data_i,
  input  logic                      byp_sop_i,
  input  logic                      byp_eop_i,
  input  logic [EMPTY_W-1:0]        byp_empty_i,
  output logic                      byp_ready_o,
  input  logic [NUM_CH-1:0]         chk_valid_i,
  input  logic [NUM_CH*DATA_W-1:0]  chk_data_i,
  input  logic [NUM_CH-1:0]         chk_sop_i,
  input  logic [NUM_CH-1:0]         chk_eop_i,
  input  logic [NUM_CH*EMPTY_W-1:0] chk_empty_i,
  output logic [NUM_CH-1:0]         chk_ready_o,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      sop_o,
  output logic                      eop_o,
  output logic [EMPTY_W-1:0]        empty_o
);
  always_comb begin
    valid_o     = 1'b0;
    data_o      = '0;
    sop_o       = 1'b0;
    eop_o       = 1'b0;
    empty_o     = '0;
    byp_ready_o = 1'b0;
    chk_ready_o = '0;
    if (en_i && byp_sel_i) begin
      valid_o     = byp_valid_i;
      data_o      = byp_data_i;
      sop_o       = byp_sop_i;
      eop_o       = byp_eop_i;
      empty_o     = byp_empty_i;
      byp_ready_o = ready_i;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (en_i && !byp_sel_i && ch_i == CH_W'(i)) begin
        valid_o        = chk_valid_i[i];
        data_o         = chk_data_i[i*DATA_W +: DATA_W];
        sop_o          = chk_sop_i[i];
        eop_o          = chk_eop_i[i];
        empty_o        = chk_empty_i[i*EMPTY_W +: EMPTY_W];
        chk_ready_o[i] = ready_i;
      end
    end
  end
endmodule

// File: rtl/nf_bypass_merge_avlstrm.sv
// nf_bypass_merge_avlstrm: re-emits bypass/checked-lane packets in order-token sequence,
// with a stall watchdog and packet/bad-lane statistics.
module nf_bypass_merge_avlstrm
  import nf_bypass_merge_avlstrm_pkg::*;
#(
  parameter int DATA_W      = 512,
  parameter int EMPTY_W     = 6,
  parameter int META_W      = 128,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ord_valid_i,
  output logic                      ord_ready_o,
  input  logic [META_W+CH_W:0]      ord_data_i,
  input  logic                      byp_valid_i,
  output logic                      byp_ready_o,
  input  logic [DATA_W-1:0]         byp_data_i,
  input  logic                      byp_sop_i,
  input  logic                      byp_eop_i,
  input  logic [EMPTY_W-1:0]        byp_empty_i,
  input  logic [NUM_CH-1:0]         chk_valid_i,
  output logic [NUM_CH-1:0]         chk_ready_o,
  input  logic [NUM_CH*DATA_W-1:0]  chk_data_i,
  input  logic [NUM_CH-1:0]         chk_sop_i,
  input  logic [NUM_CH-1:0]         chk_eop_i,
  input  logic [NUM_CH*EMPTY_W-1:0] chk_empty_i,
  output logic                      out_meta_valid_o,
  input  logic                      out_meta_ready_i,
  output logic [META_W-1:0]         out_meta_data_o,
  output logic                      out_pkt_valid_o,
  input  logic                      out_pkt_ready_i,
  output logic [DATA_W-1:0]         out_pkt_data_o,
  output logic                      out_pkt_sop_o,
  output logic                      out_pkt_eop_o,
  output logic [EMPTY_W-1:0]        out_pkt_empty_o,
  output logic [31:0]               stats_out_pkt_o,
  output logic [31:0]               stats_byp_pkt_o,
  output logic [31:0]               stats_chk_pkt_o,
  output logic [31:0]               stats_bad_ch_o,
  output logic [31:0]               stats_stall_o
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  state_e              state_q;
  logic                ord_rdy_q, meta_vld_q, byp_q, first_q;
  logic [META_W-1:0]   meta_q;
  logic [CH_W-1:0]     ch_q;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [31:0]         cnt_q [NUM_REGS];
  logic [META_W-1:0]   tok_meta;
  logic                tok_chk;
  logic [CH_W-1:0]     tok_ch;
  logic                in_pkt, src_valid, src_sop, beat, bad, stall_hit;
  assign {tok_meta, tok_chk, tok_ch} = ord_data_i;
  assign bad       = tok_chk && (32'(tok_ch) >= NUM_CH);
  assign in_pkt    = state_q == S_PKT;
  assign beat      = src_valid && out_pkt_ready_i;
  assign wd_d      = (!in_pkt || beat) ? '0 :
                     (!src_valid && wd_q != WD_W'(TIMEOUT_CYC)) ? wd_q + 1'b1 : wd_q;
  assign stall_hit = in_pkt && !src_valid && wd_q == WD_W'(TIMEOUT_CYC - 1);
  nf_lane_mux #(
    .DATA_W (DATA_W),
    .EMPTY_W(EMPTY_W),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_mux (
    .en_i       (in_pkt),
    .byp_sel_i  (byp_q),
    .ch_i       (ch_q),
    .byp_valid_i(byp_valid_i),
    .byp_data_i (byp_data_i),
    .byp_sop_i  (byp_sop_i),
    .byp_eop_i  (byp_eop_i),
    .byp_empty_i(byp_empty_i),
    .byp_ready_o(byp_ready_o),
    .chk_valid_i(chk_valid_i),
    .chk_data_i (chk_data_i),
    .chk_sop_i  (chk_sop_i),
    .chk_eop_i  (chk_eop_i),
    .chk_empty_i(chk_empty_i),
    .chk_ready_o(chk_ready_o),
    .ready_i    (out_pkt_ready_i),
    .valid_o    (src_valid),
    .data_o     (out_pkt_data_o),
    .sop_o      (src_sop),
    .eop_o      (out_pkt_eop_o),
    .empty_o    (out_pkt_empty_o)
  );
  assign out_pkt_valid_o  = src_valid;
  assign out_pkt_sop_o    = src_sop | first_q;
  assign ord_ready_o      = ord_rdy_q;
  assign out_meta_valid_o = meta_vld_q;
  assign out_meta_data_o  = meta_q;
  assign stats_out_pkt_o  = cnt_q[REG_MERGE_PKT];
  assign stats_byp_pkt_o  = cnt_q[REG_MERGE_BYP];
  assign stats_chk_pkt_o  = cnt_q[REG_MERGE_CHK];
  assign stats_bad_ch_o   = cnt_q[REG_MERGE_BADCH];
  assign stats_stall_o    = cnt_q[REG_MERGE_STALL];
  // out-of-range lane IDs on checked tokens fall back to the bypass lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ord_rdy_q  <= 1'b0;
      meta_vld_q <= 1'b0;
      byp_q      <= 1'b1;
      first_q    <= 1'b0;
      meta_q     <= '0;
      ch_q       <= '0;
      wd_q       <= '0;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      wd_q <= wd_d;
      if (stall_hit) cnt_q[REG_MERGE_STALL] <= cnt_q[REG_MERGE_STALL] + 32'd1;
      case (state_q)
        S_IDLE: begin
          if (ord_rdy_q && ord_valid_i) begin
            meta_q     <= tok_meta;
            ch_q       <= tok_ch;
            byp_q      <= !tok_chk || bad;
            ord_rdy_q  <= 1'b0;
            meta_vld_q <= 1'b1;
            state_q    <= S_META;
            if (bad) cnt_q[REG_MERGE_BADCH] <= cnt_q[REG_MERGE_BADCH] + 32'd1;
          end else begin
            ord_rdy_q <= 1'b1;
          end
        end
        S_META: begin
          if (out_meta_ready_i) begin
            meta_vld_q <= 1'b0;
            first_q    <= 1'b1;
            state_q    <= S_PKT;
          end
        end
        S_PKT: begin
          if (beat) begin
            first_q <= 1'b0;
            if (out_pkt_eop_o) begin
              state_q                <= S_IDLE;
              ord_rdy_q              <= 1'b1;
              cnt_q[REG_MERGE_PKT]   <= cnt_q[REG_MERGE_PKT] + 32'd1;
              if (byp_q) cnt_q[REG_MERGE_BYP] <= cnt_q[REG_MERGE_BYP] + 32'd1;
              else       cnt_q[REG_MERGE_CHK] <= cnt_q[REG_MERGE_CHK] + 32'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nf_bypass_merge_avlstrm.sv
// tb_nf_bypass_merge_avlstrm: directed scenarios for ordering, lane select, watchdog, bad IDs,
// backpressure and mid-packet reset; u_wd is a short-timeout copy fed the same stimulus.
module tb_nf_bypass_merge_avlstrm;
  import nf_bypass_merge_avlstrm_pkg::*;
  localparam int DW = 32, EW = 6, MW = 128, NC = 4, CW = 3;
  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic [EW-1:0] e;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic              ord_valid, byp_valid, byp_sop, byp_eop, out_meta_ready, out_pkt_ready;
  logic [MW+CW:0]    ord_data;
  logic [DW-1:0]     byp_data;
  logic [EW-1:0]     byp_empty;
  logic [NC-1:0]     chk_valid, chk_sop, chk_eop;
  logic [NC*DW-1:0]  chk_data;
  logic [NC*EW-1:0]  chk_empty;
  logic              ord_ready, byp_ready, out_meta_valid, out_pkt_valid, out_pkt_sop, out_pkt_eop;
  logic [NC-1:0]     chk_ready;
  logic [MW-1:0]     out_meta_data;
  logic [DW-1:0]     out_pkt_data;
  logic [EW-1:0]     out_pkt_empty;
  logic [31:0]       s_pkt, s_byp, s_chk, s_bad, s_stall;
  logic              w_ord_ready, w_byp_ready, w_meta_valid, w_pkt_valid, w_pkt_sop, w_pkt_eop;
  logic [NC-1:0]     w_chk_ready;
  logic [MW-1:0]     w_meta_data;
  logic [DW-1:0]     w_pkt_data;
  logic [EW-1:0]     w_pkt_empty;
  logic [31:0]       w_pkt, w_byp, w_chk, w_bad, w_stall;

  nf_bypass_merge_avlstrm #(.DATA_W(DW), .EMPTY_W(EW), .META_W(MW), .NUM_CH(NC), .CH_W(CW),
                            .TIMEOUT_CYC(1024)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ord_valid_i(ord_valid), .ord_ready_o(ord_ready), .ord_data_i(ord_data),
    .byp_valid_i(byp_valid), .byp_ready_o(byp_ready), .byp_data_i(byp_data),
    .byp_sop_i(byp_sop), .byp_eop_i(byp_eop), .byp_empty_i(byp_empty),
    .chk_valid_i(chk_valid), .chk_ready_o(chk_ready), .chk_data_i(chk_data),
    .chk_sop_i(chk_sop), .chk_eop_i(chk_eop), .chk_empty_i(chk_empty),
    .out_meta_valid_o(out_meta_valid), .out_meta_ready_i(out_meta_ready), .out_meta_data_o(out_meta_data),
    .out_pkt_valid_o(out_pkt_valid), .out_pkt_ready_i(out_pkt_ready), .out_pkt_data_o(out_pkt_data),
    .out_pkt_sop_o(out_pkt_sop), .out_pkt_eop_o(out_pkt_eop), .out_pkt_empty_o(out_pkt_empty),
    .stats_out_pkt_o(s_pkt), .stats_byp_pkt_o(s_byp), .stats_chk_pkt_o(s_chk),
    .stats_bad_ch_o(s_bad), .stats_stall_o(s_stall));

  nf_bypass_merge_avlstrm #(.DATA_W(DW), .EMPTY_W(EW), .META_W(MW), .NUM_CH(NC), .CH_W(CW),
                            .TIMEOUT_CYC(8)) u_wd (
    .clk(clk), .rst_n(rst_n),
    .ord_valid_i(ord_valid), .ord_ready_o(w_ord_ready), .ord_data_i(ord_data),
    .byp_valid_i(byp_valid), .byp_ready_o(w_byp_ready), .byp_data_i(byp_data),
    .byp_sop_i(byp_sop), .byp_eop_i(byp_eop), .byp_empty_i(byp_empty),
    .chk_valid_i(chk_valid), .chk_ready_o(w_chk_ready), .chk_data_i(chk_data),
    .chk_sop_i(chk_sop), .chk_eop_i(chk_eop), .chk_empty_i(chk_empty),
    .out_meta_valid_o(w_meta_valid), .out_meta_ready_i(out_meta_ready), .out_meta_data_o(w_meta_data),
    .out_pkt_valid_o(w_pkt_valid), .out_pkt_ready_i(out_pkt_ready), .out_pkt_data_o(w_pkt_data),
    .out_pkt_sop_o(w_pkt_sop), .out_pkt_eop_o(w_pkt_eop), .out_pkt_empty_o(w_pkt_empty),
    .stats_out_pkt_o(w_pkt), .stats_byp_pkt_o(w_byp), .stats_chk_pkt_o(w_chk),
    .stats_bad_ch_o(w_bad), .stats_stall_o(w_stall));

  // source 0 is the bypass lane, source i+1 is checked lane i
  beat_t        src_q [5][$];
  int           dly [5];
  ord_tok_t     tok_q [$];
  beat_t        out_q [$];
  logic [MW-1:0] meta_out [$];
  int  vecs = 0, errs = 0;
  bit  tgl, tstarted, touched0, held_v;
  int  tcnt, bcnt, hcnt;
  beat_t held;

  function automatic beat_t mk(int src, int pkt, int b, logic sop, logic eop);
    beat_t r;
    r.d = {8'(src), 8'(pkt), 16'(b)};
    r.sop = sop;
    r.eop = eop;
    r.e = eop ? 6'(src + 1) : 6'd0;
    return r;
  endfunction

  function automatic ord_tok_t tok(logic chk, logic [CW-1:0] ch, logic [MW-1:0] m);
    ord_tok_t t;
    t.meta = m;
    t.chk = chk;
    t.ch_id = ch;
    return t;
  endfunction

  task automatic add_pkt(int src, int pkt, int n);
    for (int b = 0; b < n; b++) src_q[src].push_back(mk(src, pkt, b, b == 0, b == n - 1));
  endtask

  task automatic clear_tb();
    for (int i = 0; i < 5; i++) begin
      src_q[i].delete();
      dly[i] = 0;
    end
    tok_q.delete();
    out_q.delete();
    meta_out.delete();
    tgl = 0; tstarted = 0; touched0 = 0; held_v = 0;
    tcnt = 0; bcnt = 0; hcnt = 0;
    ord_valid = 0; ord_data = '0;
    byp_valid = 0; byp_data = '0; byp_sop = 0; byp_eop = 0; byp_empty = '0;
    chk_valid = '0; chk_data = '0; chk_sop = '0; chk_eop = '0; chk_empty = '0;
    out_meta_ready = 1; out_pkt_ready = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_tb();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // one clock: present queue heads, sample handshakes mid-cycle, then advance past the edge
  task automatic cyc();
    beat_t b, cur;
    ord_valid = tok_q.size() != 0;
    ord_data = ord_valid ? tok_q[0] : '0;
    b = (src_q[0].size() != 0 && dly[0] == 0) ? src_q[0][0] : '0;
    byp_valid = src_q[0].size() != 0 && dly[0] == 0;
    {byp_data, byp_sop, byp_eop, byp_empty} = b;
    for (int i = 0; i < NC; i++) begin
      b = (src_q[i+1].size() != 0 && dly[i+1] == 0) ? src_q[i+1][0] : '0;
      chk_valid[i] = src_q[i+1].size() != 0 && dly[i+1] == 0;
      {chk_data[i*DW +: DW], chk_sop[i], chk_eop[i], chk_empty[i*EW +: EW]} = b;
    end
    #1;
    if (tgl) begin
      if (out_pkt_valid) tstarted = 1;
      out_pkt_ready = tstarted ? (tcnt % 2 == 0) : 1'b1;
    end
    #1;
    cur = {out_pkt_data, out_pkt_sop, out_pkt_eop, out_pkt_empty};
    if (chk_ready[0]) touched0 = 1;
    if (held_v) begin
      vecs++; hcnt++;
      if (!out_pkt_valid || cur !== held) begin
        errs++;
        $display("FAIL hold_stable: got valid=%0b beat=%h want valid=1 beat=%h", out_pkt_valid, cur, held);
      end
    end
    held_v = out_pkt_valid && !out_pkt_ready;
    held = cur;
    if (out_pkt_valid && out_pkt_ready) begin
      out_q.push_back(cur);
      if (tstarted && tcnt < 8) bcnt++;
    end
    if (out_meta_valid && out_meta_ready) meta_out.push_back(out_meta_data);
    if (ord_valid && ord_ready) void'(tok_q.pop_front());
    if (byp_valid && byp_ready) void'(src_q[0].pop_front());
    for (int i = 0; i < NC; i++) if (chk_valid[i] && chk_ready[i]) void'(src_q[i+1].pop_front());
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) if (dly[i] > 0) dly[i]--;
    if (tstarted) tcnt++;
  endtask

  task automatic run_until(int n);
    int c = 0;
    while (out_q.size() < n && c < 300) begin
      cyc();
      c++;
    end
  endtask

  task automatic test_reset();
    clear_tb();
    @(posedge clk);
    #2;
    vecs++;
    if ({ord_ready, out_meta_valid, out_pkt_valid, byp_ready, chk_ready} !== 8'h00) begin
      errs++;
      $display("FAIL reset_ctl: got %b want 00000000", {ord_ready, out_meta_valid, out_pkt_valid, byp_ready, chk_ready});
    end
    vecs++;
    if ({s_pkt, s_byp, s_chk, s_bad, s_stall} !== 160'd0) begin
      errs++;
      $display("FAIL reset_stats: got %h want 0", {s_pkt, s_byp, s_chk, s_bad, s_stall});
    end
    vecs++;
    if ({out_meta_data, out_pkt_data} !== '0) begin
      errs++;
      $display("FAIL reset_data: got %h want 0", {out_meta_data, out_pkt_data});
    end
    rst_n = 1;
    cyc();
    vecs++;
    if (ord_ready !== 1'b1) begin
      errs++;
      $display("FAIL idle_ready: got %b want 1", ord_ready);
    end
  endtask

  task automatic test_order();
    int srcs [3] = '{0, 3, 0};
    beat_t exp, got;
    do_reset();
    tok_q.push_back(tok(0, 0, 128'hA));
    tok_q.push_back(tok(1, 2, 128'hB));
    tok_q.push_back(tok(0, 5, 128'hC));
    add_pkt(0, 0, 3);
    add_pkt(3, 1, 3);
    add_pkt(0, 2, 3);
    run_until(9);
    repeat (2) cyc();
    vecs++;
    if (out_q.size() != 9) begin
      errs++;
      $display("FAIL order_count: got %0d want 9", out_q.size());
    end
    for (int k = 0; k < 9; k++) begin
      exp = mk(srcs[k/3], k/3, k%3, k%3 == 0, k%3 == 2);
      got = k < out_q.size() ? out_q[k] : '0;
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL order_beat%0d: got %h want %h", k, got, exp);
      end
    end
    vecs++;
    if (meta_out.size() != 3 || meta_out[0] !== 128'hA || meta_out[1] !== 128'hB || meta_out[2] !== 128'hC) begin
      errs++;
      $display("FAIL order_meta: got %0d entries first %h want A,B,C", meta_out.size(), meta_out.size() ? meta_out[0] : '0);
    end
    vecs++;
    if ({s_pkt, s_byp, s_chk, s_bad} !== {32'd3, 32'd2, 32'd1, 32'd0}) begin
      errs++;
      $display("FAIL order_stats: got %0d/%0d/%0d/%0d want 3/2/1/0", s_pkt, s_byp, s_chk, s_bad);
    end
  endtask

  task automatic test_lane_select();
    beat_t exp, got;
    do_reset();
    tok_q.push_back(tok(1, 1, 128'h11));
    add_pkt(1, 7, 2);
    dly[2] = 20;
    src_q[2].push_back(mk(2, 0, 0, 1'b0, 1'b1));
    run_until(1);
    repeat (2) cyc();
    exp = mk(2, 0, 0, 1'b1, 1'b1);
    got = out_q.size() ? out_q[0] : '0;
    vecs++;
    if (out_q.size() != 1 || got !== exp) begin
      errs++;
      $display("FAIL lane_beat: got %0d beats first %h want 1 beat %h", out_q.size(), got, exp);
    end
    vecs++;
    if (touched0 || src_q[1].size() != 2) begin
      errs++;
      $display("FAIL lane0_idle: got touched=%0b left=%0d want 0/2", touched0, src_q[1].size());
    end
    vecs++;
    if ({s_stall, s_chk, s_pkt} !== {32'd0, 32'd1, 32'd1}) begin
      errs++;
      $display("FAIL lane_stats: got stall=%0d chk=%0d pkt=%0d want 0/1/1", s_stall, s_chk, s_pkt);
    end
  endtask

  task automatic test_watchdog();
    beat_t exp, got;
    do_reset();
    tok_q.push_back(tok(1, 3, 128'h33));
    dly[4] = 30;
    add_pkt(4, 0, 3);
    run_until(3);
    repeat (2) cyc();
    for (int k = 0; k < 3; k++) begin
      exp = mk(4, 0, k, k == 0, k == 2);
      got = k < out_q.size() ? out_q[k] : '0;
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL wd_beat%0d: got %h want %h", k, got, exp);
      end
    end
    vecs++;
    if (w_stall !== 32'd1) begin
      errs++;
      $display("FAIL wd_stall_short: got %0d want 1", w_stall);
    end
    vecs++;
    if (s_stall !== 32'd0) begin
      errs++;
      $display("FAIL wd_stall_long: got %0d want 0", s_stall);
    end
  endtask

  task automatic test_bad_ch();
    beat_t exp, got;
    do_reset();
    tok_q.push_back(tok(1, 6, 128'h66));
    add_pkt(0, 4, 2);
    add_pkt(3, 9, 2);
    run_until(2);
    repeat (2) cyc();
    for (int k = 0; k < 2; k++) begin
      exp = mk(0, 4, k, k == 0, k == 1);
      got = k < out_q.size() ? out_q[k] : '0;
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL bad_beat%0d: got %h want %h", k, got, exp);
      end
    end
    vecs++;
    if ({s_bad, s_byp, s_chk, s_pkt} !== {32'd1, 32'd1, 32'd0, 32'd1}) begin
      errs++;
      $display("FAIL bad_stats: got bad=%0d byp=%0d chk=%0d pkt=%0d want 1/1/0/1", s_bad, s_byp, s_chk, s_pkt);
    end
  endtask

  task automatic test_backpressure();
    beat_t exp, got;
    do_reset();
    tgl = 1;
    tok_q.push_back(tok(0, 0, 128'h77));
    add_pkt(0, 3, 4);
    run_until(4);
    tgl = 0;
    out_pkt_ready = 1;
    repeat (2) cyc();
    vecs++;
    if (bcnt != 4 || hcnt != 3) begin
      errs++;
      $display("FAIL bp_rate: got %0d beats, %0d holds in 8 cycles want 4/3", bcnt, hcnt);
    end
    for (int k = 0; k < 4; k++) begin
      exp = mk(0, 3, k, k == 0, k == 3);
      got = k < out_q.size() ? out_q[k] : '0;
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL bp_beat%0d: got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    beat_t exp, got;
    do_reset();
    tok_q.push_back(tok(0, 0, 128'h1));
    tok_q.push_back(tok(0, 0, 128'h2));
    add_pkt(0, 0, 2);
    add_pkt(0, 1, 4);
    run_until(3);
    vecs++;
    if (s_pkt !== 32'd1 || out_pkt_valid !== 1'b1) begin
      errs++;
      $display("FAIL mid_pre: got pkt=%0d valid=%b want 1/1", s_pkt, out_pkt_valid);
    end
    rst_n = 0;
    #1;
    vecs++;
    if ({s_pkt, s_byp, s_chk, s_bad, s_stall} !== 160'd0 || out_pkt_valid !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: got pkt=%0d byp=%0d valid=%b want 0/0/0", s_pkt, s_byp, out_pkt_valid);
    end
    do_reset();
    tok_q.push_back(tok(1, 0, 128'h3));
    add_pkt(1, 5, 2);
    run_until(2);
    repeat (2) cyc();
    for (int k = 0; k < 2; k++) begin
      exp = mk(1, 5, k, k == 0, k == 1);
      got = k < out_q.size() ? out_q[k] : '0;
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL mid_after_beat%0d: got %h want %h", k, got, exp);
      end
    end
    vecs++;
    if ({s_pkt, s_chk} !== {32'd1, 32'd1}) begin
      errs++;
      $display("FAIL mid_after_stats: got pkt=%0d chk=%0d want 1/1", s_pkt, s_chk);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_lane_select();
    test_watchdog();
    test_bad_ch();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/nf_bypass_merge_avlstrm.md
Name: nf_bypass_merge_avlstrm

Overview:
- Successor to the single-lane bypass-back merger, generalised to NUM_CH checked pattern-matcher lanes.
- Sits after the bypass FIFO and the per-lane check FIFOs. Re-emits packets in original arrival order, driven by an order-token stream from the bypass front.
- Each token selects one source per packet: the bypass lane, or one checked lane.
- Adds a configurable stall watchdog and error accounting for bad lane IDs.

Parameters:
- DATA_W, 512, packet beat width.
- EMPTY_W, 6, width of the empty field.
- META_W, 128, metadata width carried in each order token.
- NUM_CH, 4, number of checked lanes (1..8).
- CH_W, 3, lane-ID field width; must satisfy 2^CH_W >= NUM_CH.
- TIMEOUT_CYC, 1024, number of stall cycles before a stall event is counted.

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- ord_valid / ord_ready  in / out  1 / 1  order-token handshake.
- ord_data  in  META_W+1+CH_W  order token {meta, chk, ch_id}.
- byp_valid / byp_ready  in / out  1 / 1  bypass packet handshake.
- byp_data, byp_sop, byp_eop, byp_empty  in  DATA_W, 1, 1, EMPTY_W  bypass packet beat.
- chk_valid / chk_ready  in / out  NUM_CH / NUM_CH  per-lane handshake.
- chk_data  in  NUM_CH*DATA_W  lane beats, lane i at bits [i*DATA_W +: DATA_W].
- chk_sop, chk_eop  in  NUM_CH each  per-lane framing.
- chk_empty  in  NUM_CH*EMPTY_W  per-lane empty.
- out_meta_valid / out_meta_ready  out / in  1 / 1  metadata handshake.
- out_meta_data  out  META_W  metadata.
- out_pkt_valid / out_pkt_ready  out / in  1 / 1  packet handshake.
- out_pkt_data, out_pkt_sop, out_pkt_eop, out_pkt_empty  out  DATA_W, 1, 1, EMPTY_W  output packet beat.
- stats_out_pkt, stats_byp_pkt, stats_chk_pkt, stats_bad_ch, stats_stall  out  32 each  counters.

Behaviour:
- Reset (asynchronous, Rst_n=0):
  - State goes to IDLE; all counters and the watchdog clear.
  - All valid and ready outputs are 0; data outputs are 0.
- FSM states: IDLE, META, PKT.
- IDLE:
  - ord_ready=1.
  - On ord_valid, latch meta, chk and ch_id.
  - If chk=1 and ch_id>=NUM_CH: force bypass and increment stats_bad_ch.
  - Next state is META.
- META:
  - out_meta_valid=1 with the latched meta.
  - When out_meta_ready=1, go to PKT.
- PKT:
  - Zero-latency pass-through from the selected source: out_pkt_valid = src_valid, src_ready = out_pkt_ready. All other sources see ready=0.
  - A beat transfers when valid and ready are both high.
  - On a transferred eop beat, go to IDLE and increment stats_out_pkt, plus stats_byp_pkt or stats_chk_pkt according to the source.
  - A new token is not accepted in the same cycle as eop; minimum 3 cycles per packet.
- Framing:
  - The first transferred beat of each packet is forwarded with sop=1 whether or not the source asserted it.
  - Source sop appearing mid-packet is passed through unchanged. No drop, no error.
- Watchdog:
  - Counts cycles spent in PKT with src_valid=0; clears on any transferred beat.
  - On reaching TIMEOUT_CYC, increment stats_stall once and hold the count until the next beat.
  - The watchdog never drops or reorders data.
- Backpressure: out_pkt_ready=0 holds all output fields stable while valid=1 (Avalon-ST rule). Back-to-back beats at full throughput.
- Counters: 32-bit, wrap modulo 2^32, no saturation.
- Simultaneous events: a bad-ID increment and an eop increment in the same cycle both apply; the counters are independent.
- Reset mid-packet: the partial packet is abandoned and the FSM returns to IDLE. Upstream must also be reset.

Decomposition:
- Shared package:
  - order-token typedef {meta, chk, ch_id};
  - FSM state enum;
  - stats register address constants (REG_MERGE_PKT, REG_MERGE_BYP, REG_MERGE_CHK, REG_MERGE_BADCH, REG_MERGE_STALL).
- One sub-module, nf_lane_mux: a NUM_CH+1 to 1 beat mux with ready demux, purely combinational on the select.

Test Plan:
- NUM_CH=4. Tokens [byp, ch2, byp], each packet 3 beats, out ready always 1.
  - Output order is byp, ch2, byp, 9 beats total.
  - stats_out_pkt=3, stats_byp_pkt=2, stats_chk_pkt=1.
- Token chk=1, ch_id=1. Lane 0 has a packet pending, lane 1 is empty for 20 cycles, then sends a 1-beat packet.
  - Lane 0 is untouched (chk_ready[0]=0 throughout).
  - Output is the lane-1 packet.
  - stats_stall=0 with TIMEOUT_CYC=1024.
- TIMEOUT_CYC=8; lane 3 is starved for 30 cycles, then sends a packet.
  - stats_stall=1; the packet is delivered intact.
- Token chk=1, ch_id=6 (NUM_CH=4).
  - Bypass packet is emitted; stats_bad_ch=1.
- out_pkt_ready toggles 1010 over a 4-beat packet.
  - Output data is stable while stalled; 4 beats are delivered in 8 cycles.
- Rst_n asserted on beat 2 of a 4-beat packet.
  - All counters read 0 and out_pkt_valid=0 immediately.
  - After release, the next token is processed normally.
